cellular_ram_responder: RTL and testbench

//  Synthesizable model of the Micron cellular-RAM device at the far end of the state_machine RAM controller.

---
 rtl/cellular_ram_if.sv | 26 ++
 rtl/cellular_ram_responder.sv | 174 +++++++++++++++++
 tb/tb_cellular_ram_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cellular_ram_if.sv
// Control and status pins between the cellular-RAM controller and the device.
// The 16-bit data bus is a separate inout port on the device.
interface cellular_ram_if #(
  parameter int unsigned ADDR_W = 26
);
  logic              mt_ce_n;
  logic              adv_z;
  logic              we_n;
  logic              oe_n;
  logic              mt_lb_n;
  logic              mt_ub_n;
  logic              mt_cre;
  logic [ADDR_W-1:0] addr;
  logic              wait_z;
  logic              viol;

  modport master (
    output mt_ce_n, adv_z, we_n, oe_n, mt_lb_n, mt_ub_n, mt_cre, addr,
    input  wait_z, viol
  );

  modport slave (
    input  mt_ce_n, adv_z, we_n, oe_n, mt_lb_n, mt_ub_n, mt_cre, addr,
    output wait_z, viol
  );
endinterface

// File: rtl/cellular_ram_responder.sv
// Device-side model of a Micron cellular RAM in asynchronous mode, clocked by the system clock.
// Define CELLRAM_CRE_EN to add the bus configuration register reached through mt_cre.
module cellular_ram_responder #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 4,
  parameter int unsigned WRITE_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  cellular_ram_if.slave bus,
  inout  wire  [15:0] data_ram
);
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wait_q, wait_d;
  logic                    viol_q, viol_d;
  logic                    drive_q, drive_d;
  logic [15:0]             dout_q, dout_d;
  logic [DEPTH_LOG2-1:0]   a_q, a_eff;
  logic                    mem_we;
  logic [15:0]             mem [DEPTH];
  logic [15:0]             src_word;
  logic [15:0]             lane_mask;
  logic                    ce, wr, rd;
  logic                    unused_bits;

  assign ce        = !bus.mt_ce_n;
  assign wr        = !bus.we_n;
  assign rd        = !bus.oe_n;
  assign lane_mask = {{8{!bus.mt_ub_n}}, {8{!bus.mt_lb_n}}};
  // Address captured on this edge is already the one the access uses.
  assign a_eff     = (ce && !bus.adv_z) ? bus.addr[DEPTH_LOG2-1:0] : a_q;

`ifdef CELLRAM_CRE_EN
  logic        cfg_we;
  logic [15:0] bcr_q;

  assign src_word    = bus.mt_cre ? bcr_q : mem[a_eff];
  assign unused_bits = ^bus.addr[ADDR_W-1:DEPTH_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bcr_q <= 16'h9D1F;
    else if (cfg_we) bcr_q <= data_ram;
  end
`else
  assign src_word    = mem[a_eff];
  assign unused_bits = ^{bus.addr[ADDR_W-1:DEPTH_LOG2], bus.mt_cre};
`endif

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    viol_d  = viol_q;
    drive_d = drive_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
`ifdef CELLRAM_CRE_EN
    cfg_we  = 1'b0;
`endif
    if (ce && wr && rd) viol_d = 1'b1;

    case (state_q)
      IDLE: begin
        wait_d  = 1'b1;
        drive_d = 1'b0;
        if (ce && wr) begin
          cnt_d   = CNT_W'(1);
          state_d = (WRITE_LAT <= 1) ? WR_HOLD : WR_WAIT;
          wait_d  = (WRITE_LAT <= 1);
        end else if (ce && rd) begin
          cnt_d   = CNT_W'(1);
          state_d = RD_WAIT;
          wait_d  = 1'b0;
        end
      end
      RD_WAIT: begin
        if (!ce || !rd || wr) begin
          state_d = IDLE;
          wait_d  = 1'b1;
        end else if (cnt_q == CNT_W'(READ_LAT)) begin
          state_d = RD_DRIVE;
          wait_d  = 1'b1;
          drive_d = 1'b1;
          dout_d  = src_word & lane_mask;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (!ce || !rd || wr) begin
          state_d = IDLE;
          wait_d  = 1'b1;
          drive_d = 1'b0;
        end else begin
          dout_d = src_word & lane_mask;
        end
      end
      WR_WAIT: begin
        if (!ce) begin
          state_d = IDLE;
          wait_d  = 1'b1;
        end else if (!wr) begin
          state_d = IDLE;
          wait_d  = 1'b1;
          viol_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WRITE_LAT - 1)) begin
            state_d = WR_HOLD;
            wait_d  = 1'b1;
          end
        end
      end
      WR_HOLD: begin
        wait_d = 1'b1;
        if (!ce) begin
          state_d = IDLE;
        end else if (!wr) begin
          state_d = IDLE;
`ifdef CELLRAM_CRE_EN
          cfg_we  = bus.mt_cre;
          mem_we  = !bus.mt_cre;
`else
          mem_we  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = 1'b1;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b1;
      viol_q  <= 1'b0;
      drive_q <= 1'b0;
      dout_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      viol_q  <= viol_d;
      drive_q <= drive_d;
      dout_q  <= dout_d;
      a_q     <= a_eff;
    end
  end

  // Array is not reset; lanes select which bytes commit.
  always_ff @(posedge clk) begin
    if (mem_we && !bus.mt_lb_n) mem[a_eff][7:0]  <= data_ram[7:0];
    if (mem_we && !bus.mt_ub_n) mem[a_eff][15:8] <= data_ram[15:8];
  end

  assign data_ram   = drive_q ? dout_q : 16'bz;
  assign bus.wait_z = wait_q;
  assign bus.viol   = viol_q;
endmodule

// File: tb/tb_cellular_ram_responder.sv
// Scoreboard bench for cellular_ram_responder: stimulus queues the expected ready event,
// a monitor checks it whenever wait_z returns high.
module tb_cellular_ram_responder;
  localparam int unsigned ADDR_W    = 26;
  localparam int unsigned READ_LAT  = 4;
  localparam int unsigned WRITE_LAT = 3;
  localparam logic        K_READ    = 1'b1;
  localparam logic        K_OTHER   = 1'b0;

  typedef struct packed {
    logic        kind;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dout = 16'h0;
  wire  [15:0] data_ram;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic        wz_prev = 1'b1;

  cellular_ram_if #(.ADDR_W(ADDR_W)) bus ();

  cellular_ram_responder #(
    .ADDR_W(ADDR_W), .DEPTH_LOG2(10), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .data_ram(data_ram)
  );

  assign data_ram = tb_drv ? tb_dout : 16'bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input logic kind, input logic [15:0] d, input int unsigned c);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.mt_ce_n = 1'b1; bus.adv_z = 1'b1; bus.we_n = 1'b1; bus.oe_n = 1'b1;
    bus.mt_lb_n = 1'b0; bus.mt_ub_n = 1'b0; bus.mt_cre = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic lb_n,
                          input logic ub_n, input logic cre, input int low, input logic oe_too);
    int unsigned t0;
    @(negedge clk);
    bus.mt_ce_n = 1'b0; bus.adv_z = 1'b0; bus.addr = a; bus.we_n = 1'b0; bus.oe_n = !oe_too;
    bus.mt_lb_n = lb_n; bus.mt_ub_n = ub_n; bus.mt_cre = cre;
    tb_dout = d; tb_drv = 1'b1;
    t0 = cyc + 1;
    if (low >= int'(WRITE_LAT)) push(K_OTHER, 16'h0, t0 + WRITE_LAT - 1);
    else                        push(K_OTHER, 16'h0, t0 + int'(low));
    for (int i = 0; i < low; i++) begin
      @(negedge clk);
      bus.adv_z = 1'b1;
    end
    bus.we_n = 1'b1;
    bus.oe_n = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic lb_n, input logic ub_n,
                         input logic cre, input logic [15:0] exp_d, input int abort_at,
                         input logic relatch, input logic [ADDR_W-1:0] a2);
    int unsigned t0;
    @(negedge clk);
    bus.mt_ce_n = 1'b0; bus.adv_z = 1'b0; bus.addr = a; bus.oe_n = 1'b0; bus.we_n = 1'b1;
    bus.mt_lb_n = lb_n; bus.mt_ub_n = ub_n; bus.mt_cre = cre;
    t0 = cyc + 1;
    if (abort_at > 0) push(K_OTHER, 16'h0, t0 + int'(abort_at));
    else              push(K_READ, exp_d, t0 + READ_LAT);
    for (int i = 0; i <= int'(READ_LAT); i++) begin
      @(negedge clk);
      bus.adv_z = !(relatch && i == 0);
      if (relatch && i == 0) bus.addr = a2;
      if (abort_at > 0 && i == abort_at - 1) bus.mt_ce_n = 1'b1;
    end
    idle();
    @(negedge clk);
  endtask

  // Monitor: every return of wait_z to 1 closes one access.
  always @(negedge clk) begin
    if (!rst && bus.wait_z && !wz_prev) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: wait_z rose at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ready_cycle", cyc, mon_e.cyc);
        if (mon_e.kind == K_READ) begin
          check("bus_driven", {31'h0, dut.drive_q}, 32'h1);
          check("read_data", {16'h0, data_ram}, {16'h0, mon_e.data});
        end else begin
          check("bus_released", {31'h0, dut.drive_q}, 32'h0);
        end
      end
    end
    wz_prev = bus.wait_z;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    bus.addr = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_wait_z", {31'h0, bus.wait_z}, 32'h1);
    check("reset_viol", {31'h0, bus.viol}, 32'h0);
    check("reset_bus", {31'h0, dut.drive_q}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_write(26'h3, 16'hA55A, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    do_read(26'h3, 1'b0, 1'b0, 1'b0, 16'hA55A, 0, 1'b0, '0);

    do_write(26'h5, 16'h1234, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    do_write(26'h5, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    do_read(26'h5, 1'b0, 1'b0, 1'b0, 16'h12FF, 0, 1'b0, '0);
    do_read(26'h5, 1'b1, 1'b0, 1'b0, 16'h1200, 0, 1'b0, '0);

    do_write(26'h7, 16'h7777, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    check("viol_before_short", {31'h0, bus.viol}, 32'h0);
    do_write(26'h7, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    check("viol_after_short", {31'h0, bus.viol}, 32'h1);
    do_read(26'h7, 1'b0, 1'b0, 1'b0, 16'h7777, 0, 1'b0, '0);

    do_read(26'h3, 1'b0, 1'b0, 1'b0, 16'h0, 2, 1'b0, '0);
    do_write(26'h403, 16'hBEEF, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    do_read(26'h3, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0, '0);

    do_write(26'h3, 16'h0000, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    do_read(26'h3, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0, '0);
    do_read(26'h5, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 1'b1, 26'h3);

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rereset_viol", {31'h0, bus.viol}, 32'h0);
    check("rereset_wait_z", {31'h0, bus.wait_z}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    do_read(26'h3, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0, '0);

    do_write(26'h9, 16'hCAFE, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    check("viol_both_low", {31'h0, bus.viol}, 32'h1);
    do_read(26'h9, 1'b0, 1'b0, 1'b0, 16'hCAFE, 0, 1'b0, '0);

`ifdef CELLRAM_CRE_EN
    do_write(26'h0, 16'h1111, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    do_read(26'h0, 1'b0, 1'b0, 1'b1, 16'h9D1F, 0, 1'b0, '0);
    do_write(26'h0, 16'h0010, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    do_read(26'h0, 1'b0, 1'b0, 1'b1, 16'h0010, 0, 1'b0, '0);
    do_read(26'h0, 1'b0, 1'b0, 1'b0, 16'h1111, 0, 1'b0, '0);
`endif

    repeat (20) @(negedge clk);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      $display("FAIL missing_ready: no ready seen, expected at cycle %0d", mon_e.cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
